// File: rtl/rr_shared_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
package rr_shared_reg_arbiter_pkg;

   // Arbiter FSM encoding: IDLE may grant, HOLD keeps the register stable.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // Width of an index into n items; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage : rr_shared_reg_arbiter_pkg

// File: rtl/rr_shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
//
// Handshake: req[i] is a level that the requester keeps high until it sees
// gnt[i]; gnt is a one-hot, single-cycle pulse that is both the grant and the
// acknowledge, and q_out carries the captured data in that same cycle.
// Requests raised while busy is high are not queued; they are considered
// again only once the arbiter has returned to IDLE.
interface rr_shared_reg_arbiter_if
   import rr_shared_reg_arbiter_pkg::*;
#(
   parameter int N = 8,
   parameter int R = 4
) ();
   localparam int IW = idx_w(R);

   logic [R-1:0]   req;
   logic [R*N-1:0] data_in;
   logic           flush;
   logic [R-1:0]   gnt;
   logic [IW-1:0]  owner;
   logic [N-1:0]   q_out;
   logic           q_valid;
   logic           busy;

   // Producers drive requests and data; they observe grant and register.
   modport master (
      output req, data_in, flush,
      input  gnt, owner, q_out, q_valid, busy
   );

   // The arbiter consumes requests and drives grant and register.
   modport slave (
      input  req, data_in, flush,
      output gnt, owner, q_out, q_valid, busy
   );

endinterface : rr_shared_reg_arbiter_if

// File: rtl/rr_shared_reg_arbiter_rr_pick.sv
// Combinational round-robin priority picker: searches upward from the bit
// after i_ptr, wrapping modulo R, and reports the first set request.
module rr_pick #(
   parameter int R  = 4,
   parameter int IW = 2
) (
   input  logic [R-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [IW-1:0] o_winner,
   output logic          o_any_req
);

   int w_idx;

   // Scan R positions starting just past the last winner; first hit wins.
   always_comb begin
      o_winner  = '0;
      o_any_req = 1'b0;
      w_idx     = 0;
      for (int k = 1; k <= R; k++) begin
         w_idx = int'(i_ptr) + k;
         if (w_idx >= R) w_idx = w_idx - R;
         if (!o_any_req && i_req[w_idx]) begin
            o_any_req = 1'b1;
            o_winner  = IW'(w_idx);
         end
      end
   end

endmodule : rr_pick

// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin arbiter time-sharing one N-bit capture register among R
// requesters, with a HOLD-cycle window after each load before re-arbitrating.
module rr_shared_reg_arbiter
   import rr_shared_reg_arbiter_pkg::*;
#(
   parameter int N    = 8,
   parameter int R    = 4,
   parameter int HOLD = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   rr_shared_reg_arbiter_if.slave        arb_bus,
   output state_t                        o_dbg_state
);

   localparam int IW = idx_w(R);
   localparam int CW = idx_w(HOLD);

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [IW-1:0]  r_ptr;
   logic [N-1:0]   r_q;
   logic           r_q_valid;
   logic [R-1:0]   r_gnt;
   logic [IW-1:0]  r_owner;
   logic           r_busy;

   state_t         w_state_nxt;
   logic [CW-1:0]  w_cnt_nxt;
   logic [IW-1:0]  w_ptr_nxt;
   logic [N-1:0]   w_q_nxt;
   logic           w_q_valid_nxt;
   logic [R-1:0]   w_gnt_nxt;
   logic [IW-1:0]  w_owner_nxt;
   logic           w_busy_nxt;

   logic [IW-1:0]  w_winner;
   logic           w_any_req;

   rr_pick #(
      .R  (R),
      .IW (IW)
   ) u_pick (
      .i_req     (arb_bus.req),
      .i_ptr     (r_ptr),
      .o_winner  (w_winner),
      .o_any_req (w_any_req)
   );

   // Next-state logic: grant in IDLE, count down in HOLD, flush clears data.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_ptr_nxt     = r_ptr;
      w_q_nxt       = r_q;
      w_q_valid_nxt = r_q_valid;
      w_gnt_nxt     = '0;
      w_owner_nxt   = r_owner;
      w_busy_nxt    = r_busy;

      // Flush clears the register in either state; in IDLE it also blocks
      // the grant below, and in HOLD the countdown carries on regardless.
      if (arb_bus.flush) begin
         w_q_nxt       = '0;
         w_q_valid_nxt = 1'b0;
      end

      case (r_state)
         ST_IDLE: begin
            if (w_any_req && !arb_bus.flush) begin
               w_q_nxt             = arb_bus.data_in[int'(w_winner)*N +: N];
               w_q_valid_nxt       = 1'b1;
               w_gnt_nxt[w_winner] = 1'b1;
               w_owner_nxt         = w_winner;
               w_ptr_nxt           = w_winner;
               w_busy_nxt          = 1'b1;
               w_cnt_nxt           = CW'(HOLD - 1);
               w_state_nxt         = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset parks the pointer on R-1 so that
   // requester 0 is first in line after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_ptr     <= IW'(R - 1);
         r_q       <= '0;
         r_q_valid <= 1'b0;
         r_gnt     <= '0;
         r_owner   <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_ptr     <= w_ptr_nxt;
         r_q       <= w_q_nxt;
         r_q_valid <= w_q_valid_nxt;
         r_gnt     <= w_gnt_nxt;
         r_owner   <= w_owner_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   assign arb_bus.gnt     = r_gnt;
   assign arb_bus.owner   = r_owner;
   assign arb_bus.q_out   = r_q;
   assign arb_bus.q_valid = r_q_valid;
   assign arb_bus.busy    = r_busy;
   assign o_dbg_state     = r_state;

endmodule : rr_shared_reg_arbiter

// File: tb/tb_rr_shared_reg_arbiter.sv
// Bench for rr_shared_reg_arbiter: directed scenarios plus random traffic,
// scored against a cycle-level model of the arbitration rules.
module tb_rr_shared_reg_arbiter;
   import rr_shared_reg_arbiter_pkg::*;

   localparam int N    = 8;
   localparam int R    = 4;
   localparam int HOLD = 2;
   localparam int IW   = idx_w(R);
   localparam int GW   = 16 + R + N;        // {edge, gnt, q}
   localparam int SW   = IW + 1 + 1 + N;    // {owner, busy, q_valid, q}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rr_shared_reg_arbiter_if #(.N(N), .R(R)) arb_bus ();
   state_t dbg_state;

   rr_shared_reg_arbiter #(.N(N), .R(R), .HOLD(HOLD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .arb_bus     (arb_bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [GW-1:0] exp_q[$];
   logic [SW-1:0] st_q[$];
   int vectors    = 0;
   int miscompares = 0;
   int drv_edge   = 0;
   int mon_edge   = 0;
   bit mon_en     = 1'b0;

   // reference model state
   int         m_ptr;
   int         m_owner;
   int         m_last;
   bit         m_have;
   logic [N-1:0] m_q;
   logic       m_qv;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, mon_edge, act, exp);
      end
   endtask

   function automatic int rr_win(input int ptr, input logic [R-1:0] r);
      for (int k = 1; k <= R; k++)
         if (r[(ptr + k) % R]) return (ptr + k) % R;
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = R - 1; m_owner = 0; m_last = 0; m_have = 0; m_q = '0; m_qv = 0;
      exp_q.delete(); st_q.delete();
      drv_edge = 0; mon_edge = 0;
   endtask

   // ---------------- driver ----------------
   // Called at a negedge: applies inputs for the next rising edge, predicts
   // that edge's outcome, then waits for the following negedge.
   task automatic drive_cycle(input logic [R-1:0] rq, input logic [R*N-1:0] d,
                              input logic fl);
      bit           idle;
      bit           busy;
      int           w;
      logic [R-1:0] g;
      arb_bus.req = rq; arb_bus.data_in = d; arb_bus.flush = fl;
      idle = !m_have || (drv_edge >= m_last + HOLD + 1);
      if (fl) begin m_q = '0; m_qv = 1'b0; end
      if (idle && rq != '0 && !fl) begin
         w = rr_win(m_ptr, rq);
         g = '0; g[w] = 1'b1;
         m_q = d[w*N +: N]; m_qv = 1'b1;
         m_ptr = w; m_owner = w; m_last = drv_edge; m_have = 1'b1;
         exp_q.push_back({16'(drv_edge), g, m_q});
      end
      busy = m_have && (drv_edge < m_last + HOLD);
      st_q.push_back({IW'(m_owner), busy, m_qv, m_q});
      drv_edge++;
      @(negedge clk);
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_q_out"},   int'(arb_bus.q_out),   0);
      chk({tag, "_q_valid"}, int'(arb_bus.q_valid), 0);
      chk({tag, "_gnt"},     int'(arb_bus.gnt),     0);
      chk({tag, "_owner"},   int'(arb_bus.owner),   0);
      chk({tag, "_busy"},    int'(arb_bus.busy),    0);
      chk({tag, "_state"},   int'(dbg_state),       int'(ST_IDLE));
   endtask

   task automatic release_reset();
      arb_bus.req = '0; arb_bus.flush = 1'b0;
      model_reset();
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic go_idle();
      repeat (HOLD + 1) drive_cycle('0, '0, 1'b0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [GW-1:0] ge;
      logic [SW-1:0] se;
      forever begin
         @(posedge clk);
         #2;
         if (mon_en) begin
            if (st_q.size() == 0) begin
               chk("state_queue_empty", 1, 0);
            end else begin
               se = st_q.pop_front();
               chk("q_out",   int'(arb_bus.q_out),   int'(se[N-1:0]));
               chk("q_valid", int'(arb_bus.q_valid), int'(se[N]));
               chk("busy",    int'(arb_bus.busy),    int'(se[N+1]));
               chk("dbg_state", int'(dbg_state),     int'(se[N+1]));
               chk("owner",   int'(arb_bus.owner),   int'(se[SW-1 -: IW]));
            end
            if (arb_bus.gnt != '0) begin
               if (exp_q.size() == 0 || int'(exp_q[0][GW-1 -: 16]) != mon_edge) begin
                  chk("gnt_spurious", int'(arb_bus.gnt), 0);
               end else begin
                  ge = exp_q.pop_front();
                  chk("gnt",       int'(arb_bus.gnt),   int'(ge[N +: R]));
                  chk("gnt_q_out", int'(arb_bus.q_out), int'(ge[N-1:0]));
               end
            end else if (exp_q.size() != 0 && int'(exp_q[0][GW-1 -: 16]) == mon_edge) begin
               ge = exp_q.pop_front();
               chk("gnt_missing", int'(arb_bus.gnt), int'(ge[N +: R]));
            end
            mon_edge++;
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [R*N-1:0] din_rr;
   initial begin
      din_rr = {8'h43, 8'h32, 8'h21, 8'h10};
      rst_n = 1'b0;
      arb_bus.req = '0; arb_bus.data_in = '0; arb_bus.flush = 1'b0;
      repeat (3) @(negedge clk);
      reset_check("por");
      release_reset();

      // Round-robin rotation with all requesters active.
      repeat (14) drive_cycle(4'b1111, din_rr, 1'b0);
      go_idle();

      // Request arriving during HOLD is served one edge after IDLE returns.
      drive_cycle(4'b0001, din_rr, 1'b0);
      repeat (3) drive_cycle(4'b0100, din_rr, 1'b0);
      go_idle();

      // Flush collides with a request in IDLE, then the request proceeds.
      drive_cycle(4'b0010, din_rr, 1'b1);
      drive_cycle(4'b0010, din_rr, 1'b0);
      go_idle();

      // Wrap/skip: pointer parked on 2, only 0 and 1 requesting.
      drive_cycle(4'b0100, din_rr, 1'b0);
      go_idle();
      repeat (9) drive_cycle(4'b0011, din_rr, 1'b0);
      go_idle();

      // Single requester re-granted every HOLD+1 edges.
      repeat (12) drive_cycle(4'b1000, din_rr, 1'b0);
      go_idle();

      // Random traffic with occasional flushes and withdrawn requests.
      for (int i = 0; i < 400; i++) begin
         drive_cycle(R'($urandom_range(0, (1 << R) - 1)),
                     {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)},
                     ($urandom_range(0, 7) == 0));
      end
      go_idle();

      // Asynchronous reset mid-HOLD with 0x5A captured.
      drive_cycle(4'b0001, {24'h0, 8'h5A}, 1'b0);
      mon_en = 1'b0;
      #1 rst_n = 1'b0;
      #1 reset_check("async_rst");
      @(negedge clk);
      @(negedge clk);
      release_reset();
      repeat (6) drive_cycle(4'b1111, din_rr, 1'b0);
      go_idle();

      chk("pending_grants", exp_q.size(), 0);
      chk("pending_states", st_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_rr_shared_reg_arbiter
